// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one 16x8 single-port RAM between requesters A and B.
// Define RAM_ARB_INIT_EN to compile in the post-reset FILL sweep of all 16 words.
module ram_port_arbiter #(
    parameter logic [7:0] FILL = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_a,
    input  logic       we_a,
    input  logic [3:0] addr_a,
    input  logic [7:0] wdata_a,
    input  logic       req_b,
    input  logic       we_b,
    input  logic [3:0] addr_b,
    input  logic [7:0] wdata_b,
    output logic       gnt_a,
    output logic       gnt_b,
    output logic       rvalid_a,
    output logic       rvalid_b,
    output logic [7:0] rdata,
    output logic       init_busy,
    output logic       ram_en,
    output logic [3:0] ram_addr,
    output logic [7:0] ram_din,
    input  logic [7:0] ram_dout
);

    localparam int unsigned AW = 4;
    localparam int unsigned DW = 8;

`ifdef RAM_ARB_INIT_EN
    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_ARB  = 1'b1;

    logic [0:0]    r_state;
    logic [0:0]    w_state_nxt;
    logic [AW-1:0] r_cnt;
    logic [AW-1:0] w_cnt_nxt;
    logic          w_init;
`endif

    logic          r_last_b;
    logic          r_gnt_a;
    logic          r_gnt_b;
    logic          r_ram_en;
    logic [AW-1:0] r_ram_addr;
    logic [DW-1:0] r_ram_din;
    logic          r_pend_a;
    logic          r_pend_b;
    logic          r_rvalid_a;
    logic          r_rvalid_b;

    logic          w_last_b_nxt;
    logic          w_ram_en_nxt;
    logic [AW-1:0] w_ram_addr_nxt;
    logic [DW-1:0] w_ram_din_nxt;
    logic          w_arb_ok;
    logic          w_el_a;
    logic          w_el_b;
    logic          w_win_a;
    logic          w_win_b;

`ifdef RAM_ARB_INIT_EN
    assign w_init = (r_state == ST_INIT);
    // The last sweep edge already arbitrates, so the first grant follows init_busy directly.
    assign w_arb_ok = ~w_init | (r_cnt == AW'(15));
`else
    assign w_arb_ok = 1'b1;
`endif

    // A requester in its grant cycle is masked so a held req is not granted twice.
    assign w_el_a  = req_a & ~r_gnt_a;
    assign w_el_b  = req_b & ~r_gnt_b;
    assign w_win_a = w_arb_ok & w_el_a & (~w_el_b | r_last_b);
    assign w_win_b = w_arb_ok & w_el_b & (~w_el_a | ~r_last_b);

    // Next-state and next-output logic.
    always_comb begin
        w_last_b_nxt   = r_last_b;
        w_ram_en_nxt   = 1'b0;
        w_ram_addr_nxt = r_ram_addr;
        w_ram_din_nxt  = r_ram_din;
`ifdef RAM_ARB_INIT_EN
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        if (w_init) begin
            w_cnt_nxt = r_cnt + AW'(1);
            if (r_cnt == AW'(15)) begin
                w_state_nxt = ST_ARB;
            end
        end
`endif
        if (w_win_a) begin
            w_ram_en_nxt   = we_a;
            w_ram_addr_nxt = addr_a;
            w_ram_din_nxt  = wdata_a;
            w_last_b_nxt   = 1'b0;
        end else if (w_win_b) begin
            w_ram_en_nxt   = we_b;
            w_ram_addr_nxt = addr_b;
            w_ram_din_nxt  = wdata_b;
            w_last_b_nxt   = 1'b1;
        end
    end

    // State and output registers; pend_* -> rvalid_* form the read-owner shift register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
`ifdef RAM_ARB_INIT_EN
            r_state    <= ST_INIT;
            r_cnt      <= '0;
`endif
            r_last_b   <= 1'b1;
            r_gnt_a    <= 1'b0;
            r_gnt_b    <= 1'b0;
            r_ram_en   <= 1'b0;
            r_ram_addr <= '0;
            r_ram_din  <= '0;
            r_pend_a   <= 1'b0;
            r_pend_b   <= 1'b0;
            r_rvalid_a <= 1'b0;
            r_rvalid_b <= 1'b0;
        end else begin
`ifdef RAM_ARB_INIT_EN
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
`endif
            r_last_b   <= w_last_b_nxt;
            r_gnt_a    <= w_win_a;
            r_gnt_b    <= w_win_b;
            r_ram_en   <= w_ram_en_nxt;
            r_ram_addr <= w_ram_addr_nxt;
            r_ram_din  <= w_ram_din_nxt;
            r_pend_a   <= w_win_a & ~we_a;
            r_pend_b   <= w_win_b & ~we_b;
            r_rvalid_a <= r_pend_a;
            r_rvalid_b <= r_pend_b;
        end
    end

    assign gnt_a    = r_gnt_a;
    assign gnt_b    = r_gnt_b;
    assign rvalid_a = r_rvalid_a;
    assign rvalid_b = r_rvalid_b;
    assign rdata    = ram_dout;

`ifdef RAM_ARB_INIT_EN
    // During the sweep the RAM port is driven straight from the counter.
    assign init_busy = w_init;
    assign ram_en    = w_init ? 1'b1 : r_ram_en;
    assign ram_addr  = w_init ? r_cnt : r_ram_addr;
    assign ram_din   = w_init ? FILL : r_ram_din;
`else
    assign init_busy = 1'b0;
    assign ram_en    = r_ram_en;
    assign ram_addr  = r_ram_addr;
    assign ram_din   = r_ram_din;
`endif

endmodule
